// File: rtl/io_bus_ctrl.sv
// Z80 I/O-space controller: base/mask device decode, per-device wait states,
// single-clock rd/wr strobes, registered read data and a control latch.
module io_bus_ctrl #(
    parameter int                      NDEV      = 4,
    parameter int                      ABITS     = 8,
    parameter logic [NDEV*ABITS-1:0]   BASE      = {8'hFC, 8'hFA, 8'hF8, 8'hFE},
    parameter logic [NDEV*ABITS-1:0]   MASK      = {8'hFE, 8'hFF, 8'hFE, 8'hFF},
    parameter logic [NDEV*4-1:0]       WAITS     = {4'd1, 4'd3, 4'd0, 4'd0},
    parameter logic [ABITS-1:0]        CTRL_ADDR = {ABITS{1'b1}},
    parameter int                      CTRL_W    = 3,
    parameter int                      CTRL_LSB  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 ce_i,
    input  logic                 iorq_i,
    input  logic                 rd_i,
    input  logic                 wr_i,
    input  logic [ABITS-1:0]     a_i,
    input  logic [7:0]           d_in_i,
    output logic [7:0]           d_out_o,
    output logic                 wait_n_o,
    output logic [NDEV-1:0]      dev_cs_o,
    output logic [NDEV-1:0]      dev_rd_o,
    output logic [NDEV-1:0]      dev_wr_o,
    input  logic [NDEV*8-1:0]    dev_q_i,
    input  logic                 ctrl_in_i,
    output logic [CTRL_W-1:0]    ctrl_o
);

    localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              dev_hit_q, dev_hit_d;
    logic              ctrl_hit_q, ctrl_hit_d;
    logic              rd_dir_q, rd_dir_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wait_n_q, wait_n_d;
    logic [NDEV-1:0]   cs_q, cs_d;
    logic [NDEV-1:0]   rd_q, rd_d;
    logic [NDEV-1:0]   wr_q, wr_d;
    logic [7:0]        d_out_q, d_out_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic              dev_hit_s;
    logic              ctrl_hit_s;
    logic [IW-1:0]     idx_s;
    logic [3:0]        waits_s;
    logic [7:0]        dev_data_s;
    logic              start_s;
    logic              enter_s;
    logic [NDEV-1:0]   sel_s;
    logic              unused_s;

    // Only the latch field of the write data is consumed.
    assign unused_s = ^d_in_i;

    // Address decode; walking downwards lets the lowest matching device win.
    always_comb begin
        dev_hit_s  = 1'b0;
        idx_s      = '0;
        waits_s    = 4'd0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if ((a_i & MASK[i*ABITS +: ABITS]) == (BASE[i*ABITS +: ABITS] & MASK[i*ABITS +: ABITS])) begin
                dev_hit_s = 1'b1;
                idx_s     = IW'(i);
                waits_s   = WAITS[i*4 +: 4];
            end else begin
                dev_hit_s = dev_hit_s;
            end
        end
        ctrl_hit_s = !dev_hit_s && (a_i == CTRL_ADDR);
        start_s    = !iorq_i && (rd_i ^ wr_i);
    end

    // Read data of the captured device.
    always_comb begin
        dev_data_s = 8'hFF;
        for (int i = 0; i < NDEV; i++) begin
            if (idx_q == IW'(i)) begin
                dev_data_s = dev_q_i[i*8 +: 8];
            end else begin
                dev_data_s = dev_data_s;
            end
        end
    end

    // Bus FSM next state; strobes default low so they never outlive one clock.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dev_hit_d  = dev_hit_q;
        ctrl_hit_d = ctrl_hit_q;
        rd_dir_d   = rd_dir_q;
        cnt_d      = cnt_q;
        wait_n_d   = wait_n_q;
        cs_d       = cs_q;
        rd_d       = '0;
        wr_d       = '0;
        d_out_d    = d_out_q;
        ctrl_d     = ctrl_q;
        enter_s    = 1'b0;
        sel_s      = '0;
        if (ce_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        idx_d      = idx_s;
                        dev_hit_d  = dev_hit_s;
                        ctrl_hit_d = ctrl_hit_s;
                        rd_dir_d   = !rd_i;
                        cnt_d      = waits_s;
                        if (waits_s != 4'd0) begin
                            state_d  = ST_WAIT;
                            wait_n_d = 1'b0;
                        end else begin
                            state_d  = ST_ACCESS;
                            enter_s  = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        cnt_d    = 4'd0;
                        state_d  = ST_ACCESS;
                        wait_n_d = 1'b1;
                        enter_s  = 1'b1;
                    end else begin
                        cnt_d    = cnt_q - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (rd_dir_q) begin
                        if (dev_hit_q) begin
                            d_out_d = dev_data_s;
                        end else if (ctrl_hit_q) begin
                            d_out_d = {7'd0, ctrl_in_i};
                        end else begin
                            d_out_d = 8'hFF;
                        end
                    end else if (ctrl_hit_q) begin
                        ctrl_d = d_in_i[CTRL_LSB +: CTRL_W];
                    end else begin
                        ctrl_d = ctrl_q;
                    end
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (iorq_i) begin
                        state_d = ST_IDLE;
                        d_out_d = 8'hFF;
                        cs_d    = '0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    wait_n_d = 1'b1;
                    cs_d     = '0;
                    d_out_d  = 8'hFF;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (enter_s) begin
            for (int i = 0; i < NDEV; i++) begin
                sel_s[i] = dev_hit_d && (idx_d == IW'(i));
            end
            cs_d = sel_s;
            if (rd_dir_d) begin
                rd_d = sel_s;
            end else begin
                wr_d = sel_s;
            end
        end else begin
            sel_s = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            dev_hit_q  <= 1'b0;
            ctrl_hit_q <= 1'b0;
            rd_dir_q   <= 1'b0;
            cnt_q      <= 4'd0;
            wait_n_q   <= 1'b1;
            cs_q       <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            d_out_q    <= 8'hFF;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dev_hit_q  <= dev_hit_d;
            ctrl_hit_q <= ctrl_hit_d;
            rd_dir_q   <= rd_dir_d;
            cnt_q      <= cnt_d;
            wait_n_q   <= wait_n_d;
            cs_q       <= cs_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            d_out_q    <= d_out_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign d_out_o  = d_out_q;
    assign wait_n_o = wait_n_q;
    assign dev_cs_o = cs_q;
    assign dev_rd_o = rd_q;
    assign dev_wr_o = wr_q;
    assign ctrl_o   = ctrl_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: expected read data queued at issue and
// checked once the cycle has reached its data phase.
module tb_io_bus_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        iorq;
    logic        rd;
    logic        wr;
    logic [7:0]  a;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        wait_n;
    logic [3:0]  dev_cs;
    logic [3:0]  dev_rd;
    logic [3:0]  dev_wr;
    logic [31:0] dev_q;
    logic        ctrl_in;
    logic [2:0]  ctrl;

    io_bus_ctrl dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .ce_i     (ce),
        .iorq_i   (iorq),
        .rd_i     (rd),
        .wr_i     (wr),
        .a_i      (a),
        .d_in_i   (d_in),
        .d_out_o  (d_out),
        .wait_n_o (wait_n),
        .dev_cs_o (dev_cs),
        .dev_rd_o (dev_rd),
        .dev_wr_o (dev_wr),
        .dev_q_i  (dev_q),
        .ctrl_in_i(ctrl_in),
        .ctrl_o   (ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];

    int         st_clk;
    int         wait_cnt;
    int         strobe_at;
    int         ce_idx;
    logic [3:0] rd_mask;
    logic [3:0] wr_mask;
    logic [3:0] cs_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        st_clk    = 0;
        wait_cnt  = 0;
        strobe_at = 0;
        ce_idx    = 0;
        rd_mask   = 4'b0000;
        wr_mask   = 4'b0000;
        cs_seen   = 4'b0000;
    endtask

    task automatic tick(input logic ce_v);
        logic w_before;
        ce       = ce_v;
        w_before = wait_n;
        @(posedge clk);
        #1;
        if (ce_v) begin
            ce_idx++;
            if (!w_before) wait_cnt++;
        end
        st_clk += $countones(dev_rd | dev_wr);
        if (((dev_rd | dev_wr) != 4'b0000) && (strobe_at == 0)) strobe_at = ce_idx;
        rd_mask |= dev_rd;
        wr_mask |= dev_wr;
        cs_seen |= dev_cs;
    endtask

    // One complete I/O cycle; exp_dev < 0 means no device should be selected.
    task automatic io(input string tag, input logic [7:0] addr, input logic is_rd,
                      input logic [7:0] wdata, input int exp_dev, input int k,
                      input logic [7:0] exp_rd, input int extra);
        logic [3:0] oh;
        logic [7:0] e;
        int         nce;
        oh = 4'b0000;
        if (exp_dev >= 0) oh = 4'b0001 << exp_dev;
        mon_clear();
        a    = addr;
        d_in = wdata;
        iorq = 1'b0;
        rd   = !is_rd;
        wr   = is_rd;
        if (is_rd) exp_q.push_back(exp_rd);
        nce = k + 2 + extra;
        for (int c = 1; c <= nce; c++) begin
            tick(1'b1);
            if (c == k + 1 && is_rd) check({tag, " early"}, {24'd0, d_out}, 32'hFF);
            tick(1'b0);
        end
        check({tag, " rdmask"}, {28'd0, rd_mask}, is_rd ? {28'd0, oh} : 32'd0);
        check({tag, " wrmask"}, {28'd0, wr_mask}, is_rd ? 32'd0 : {28'd0, oh});
        check({tag, " strobe_clks"}, st_clk, (exp_dev >= 0) ? 32'd1 : 32'd0);
        check({tag, " wait_ticks"}, wait_cnt, k);
        if (exp_dev >= 0) check({tag, " strobe_at"}, strobe_at, k + 1);
        check({tag, " cs"}, {28'd0, dev_cs}, {28'd0, oh});
        if (is_rd) begin
            e = exp_q.pop_front();
            check({tag, " d_out"}, {24'd0, d_out}, {24'd0, e});
        end
        iorq = 1'b1;
        rd   = 1'b1;
        wr   = 1'b1;
        tick(1'b1);
        check({tag, " idle d_out"}, {24'd0, d_out}, 32'hFF);
        check({tag, " idle cs"}, {28'd0, dev_cs}, 32'd0);
        tick(1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        ce      = 1'b0;
        iorq    = 1'b1;
        rd      = 1'b1;
        wr      = 1'b1;
        a       = 8'h00;
        d_in    = 8'h00;
        dev_q   = 32'hD3C2_5AA0;
        ctrl_in = 1'b0;
        mon_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset wait_n", {31'd0, wait_n}, 32'd1);
        check("reset d_out", {24'd0, d_out}, 32'hFF);
        check("reset ctrl", {29'd0, ctrl}, 32'd0);
        check("reset strobes", {20'd0, dev_cs, dev_rd, dev_wr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0);

        io("in F9",   8'hF9, 1'b1, 8'h00, 1,  0, 8'h5A, 0);
        io("out FA",  8'hFA, 1'b0, 8'h77, 2,  3, 8'h00, 0);
        io("out FF",  8'hFF, 1'b0, 8'h38, -1, 0, 8'h00, 0);
        check("ctrl latch", {29'd0, ctrl}, 32'd7);
        ctrl_in = 1'b1;
        io("in FF",   8'hFF, 1'b1, 8'h00, -1, 0, 8'h01, 0);
        check("ctrl kept", {29'd0, ctrl}, 32'd7);
        io("in 10",   8'h10, 1'b1, 8'h00, -1, 0, 8'hFF, 0);
        io("held F9", 8'hF9, 1'b1, 8'h00, 1,  0, 8'h5A, 10);
        io("in FC",   8'hFC, 1'b1, 8'h00, 3,  1, 8'hD3, 0);
        io("in FE",   8'hFE, 1'b1, 8'h00, 0,  0, 8'hA0, 0);

        // Interrupt acknowledge (rd=wr=1) and both-low must both be ignored.
        mon_clear();
        a    = 8'hF9;
        iorq = 1'b0;
        rd   = 1'b1;
        wr   = 1'b1;
        repeat (6) begin
            tick(1'b1);
            tick(1'b0);
        end
        rd = 1'b0;
        wr = 1'b0;
        repeat (6) begin
            tick(1'b1);
            tick(1'b0);
        end
        check("intack strobes", st_clk, 0);
        check("intack waits", wait_cnt, 0);
        check("intack cs", {28'd0, cs_seen}, 32'd0);
        check("intack d_out", {24'd0, d_out}, 32'hFF);
        iorq = 1'b1;
        rd   = 1'b1;
        wr   = 1'b1;
        tick(1'b1);
        tick(1'b0);

        // Asynchronous reset while waiting on dev2.
        a    = 8'hFA;
        d_in = 8'h55;
        iorq = 1'b0;
        wr   = 1'b0;
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        check("mid wait low", {31'd0, wait_n}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async wait_n", {31'd0, wait_n}, 32'd1);
        check("async ctrl", {29'd0, ctrl}, 32'd0);
        check("async d_out", {24'd0, d_out}, 32'hFF);
        iorq = 1'b1;
        wr   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0);
        io("post rst", 8'hF9, 1'b1, 8'h00, 1, 0, 8'h5A, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
